// File: rtl/mips_avalon_pkg.sv
// ---------------------------------------------------------------------------
// mips_avalon_pkg
// Shared definitions for the MIPS load/store to Avalon-MM master:
//   size_e    - request access size encoding (byte/half/word/illegal)
//   state_e   - master FSM states
//   BE_*      - byteenable patterns for the naturally aligned lanes
//   req_bad() - illegal-size / misalignment classification of a request
// ---------------------------------------------------------------------------
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // A request that must never reach the bus: illegal size or an address
  // that is not naturally aligned for its size.
  function automatic logic req_bad(input size_e sz, input logic [1:0] addr_lo);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_mem_lane_align.sv
// ---------------------------------------------------------------------------
// mips_mem_lane_align
// Purely combinational lane steering between a MIPS register view and a
// 32-bit little-endian Avalon data bus.
// Ports:
//   size       in  access size (size_e)
//   addr_lo    in  byte offset within the word
//   sgn        in  1 = sign-extend load data, 0 = zero-extend
//   wdata      in  store data, LSB-justified
//   rdata      in  raw bus read data
//   byteenable out active byte lanes
//   wdata_lane out store data moved onto its lanes, unused lanes zero
//   rdata_ext  out load data moved down to bit 0 and extended
// ---------------------------------------------------------------------------
module mips_mem_lane_align
  import mips_avalon_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic        [4:0]  sh_b;
  logic        [4:0]  sh_h;

  assign sh_b = {addr_lo, 3'b000};
  assign sh_h = {addr_lo[1], 4'b0000};

  always_comb begin
    byteenable = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    lane_b     = 8'sh0;
    lane_h     = 16'sh0;
    case (size)
      SZ_BYTE: begin
        byteenable = BE_BYTE0 << addr_lo;
        wdata_lane = {24'h0, wdata[7:0]} << sh_b;
        lane_b     = 8'(rdata >> sh_b);
        if (sgn) rdata_ext = 32'(lane_b);
        else     rdata_ext = {24'h0, lane_b};
      end
      SZ_HALF: begin
        byteenable = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_lane = {16'h0, wdata[15:0]} << sh_h;
        lane_h     = 16'(rdata >> sh_h);
        if (sgn) rdata_ext = 32'(lane_h);
        else     rdata_ext = {16'h0, lane_h};
      end
      SZ_WORD: begin
        byteenable = BE_WORD;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
      default: begin
        byteenable = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mips_avalon_master.sv
// ---------------------------------------------------------------------------
// mips_avalon_master
// Converts single MIPS load/store requests into Avalon-MM read/write
// transfers, one transaction outstanding at a time.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_write        1 store, 0 load
//   req_size         00 byte, 01 half, 10 word, 11 illegal
//   req_signed       sign-extend load data
//   req_addr         byte address
//   req_wdata        store data, LSB-justified
//   resp_valid       one-cycle completion pulse
//   resp_rdata       extended load data (0 for stores and errors)
//   resp_err         misaligned / illegal size / timeout
//   address, read, write, writedata, byteenable, waitrequest, readdata
//                    Avalon-MM master interface
// Build option: define MIPS_AVALON_MASTER_TIMEOUT_EN to abort a transfer
// after TIMEOUT_CYCLES bus cycles of waitrequest; otherwise BUSY waits
// indefinitely.
// ---------------------------------------------------------------------------
module mips_avalon_master
  import mips_avalon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  state_e      state_q, state_nx;
  logic        accept;
  logic        bad_req;
  logic        timeout_hit;

  // Registered request; data only, qualified everywhere by the FSM state.
  logic        write_q;
  size_e       size_q;
  logic        sgn_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;

  assign accept  = req_valid & req_ready;
  assign bad_req = req_bad(size_e'(req_size), req_addr[1:0]);

  mips_mem_lane_align u_lane (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .sgn        (sgn_q),
    .wdata      (wdata_q),
    .rdata      (readdata),
    .byteenable (be_lane),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Count bus cycles spent stalled; the last allowed one triggers the abort.
  assign timeout_hit = (state_q == ST_BUSY) && waitrequest &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == ST_BUSY) && waitrequest && !timeout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_nx = bad_req ? ST_RESP : ST_BUSY;
      ST_BUSY: if (!waitrequest || timeout_hit) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output logic; everything is gated by state so reset clears it at once.
  always_comb begin
    req_ready  = (state_q == ST_IDLE) && rst;
    read       = 1'b0;
    write      = 1'b0;
    address    = 32'h0;
    writedata  = 32'h0;
    byteenable = 4'b0000;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    case (state_q)
      ST_BUSY: begin
        read       = !write_q;
        write      = write_q;
        address    = {addr_q[31:2], 2'b00};
        writedata  = write_q ? wdata_lane : 32'h0;
        byteenable = be_lane;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  // Request capture and load-data capture
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      size_q  <= size_e'(req_size);
      sgn_q   <= req_signed;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= bad_req;
      rdata_q <= 32'h0;
    end else if (state_q == ST_BUSY) begin
      if (!waitrequest) begin
        if (!write_q) rdata_q <= rdata_ext;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_avalon_master.sv
module tb_mips_avalon_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_avalon_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    int          waits;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_nbus;
    int          e_lat;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request, act as an Avalon slave inserting v.waits wait states,
  // and check bus signals and the response. With noise set, req_valid is
  // held high while the transfer is in flight and must be ignored.
  task automatic run_vec(input vec_t v, input string tag, input bit noise);
    int          wleft = v.waits;
    int          nbus = 0;
    int          lat = 0;
    bit          got = 0;
    bit          stable = 1;
    logic [31:0] a0 = 32'h0, wd0 = 32'h0;
    logic [3:0]  be0 = 4'h0;
    logic        rd0 = 1'b0, wr0 = 1'b0;
    @(negedge clk);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_write  = v.wr;
    req_size   = v.sz;
    req_signed = v.sg;
    req_addr   = v.addr;
    req_wdata  = v.wd;
    req_valid  = 1'b1;
    @(negedge clk);
    if (noise) begin
      req_write = 1'b1;
      req_addr  = 32'h12345678;
    end else begin
      req_valid = 1'b0;
    end
    for (int c = 1; c <= 200 && !got; c++) begin
      readdata = v.rd;
      if (read || write) begin
        if (nbus == 0) begin
          a0 = address; be0 = byteenable; wd0 = writedata; rd0 = read; wr0 = write;
        end else if (address !== a0 || byteenable !== be0 || writedata !== wd0 ||
                     read !== rd0 || write !== wr0) begin
          stable = 0;
        end
        nbus++;
        waitrequest = (wleft > 0);
        if (wleft > 0) wleft--;
      end else begin
        waitrequest = 1'b0;
      end
      if (resp_valid) begin
        got = 1;
        lat = c;
        req_valid = 1'b0;
        chk({tag, "_rdata"}, resp_rdata, v.e_rdata);
        chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, v.e_err});
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    chk({tag, "_resp_seen"}, {31'h0, got}, 32'h1);
    chk({tag, "_buscycles"}, nbus, v.e_nbus);
    chk({tag, "_latency"}, lat, v.e_lat);
    if (nbus > 0) begin
      chk({tag, "_address"}, a0, v.e_addr);
      chk({tag, "_be"}, {28'h0, be0}, {28'h0, v.e_be});
      chk({tag, "_dir"}, {30'h0, rd0, wr0}, v.wr ? 32'h1 : 32'h2);
      chk({tag, "_stable"}, {31'h0, stable}, 32'h1);
      if (v.wr) chk({tag, "_wdata"}, wd0, v.e_wd);
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_ready_back"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vto;
    int   busy_cnt;
    bit   quiet;

    //        wr sz    sg addr          wd            w  rd            e_addr        be    e_wd          e_rdata       err nb lat
    vt[0]  = '{0, 2'b10, 0, 32'hBFC00004, 32'h0,        2, 32'hDEADBEEF, 32'hBFC00004, 4'hF, 32'h0,        32'hDEADBEEF, 0, 3, 4};
    vt[1]  = '{0, 2'b00, 1, 32'hBFC00003, 32'h0,        0, 32'h80123456, 32'hBFC00000, 4'h8, 32'h0,        32'hFFFFFF80, 0, 1, 2};
    vt[2]  = '{0, 2'b00, 0, 32'hBFC00003, 32'h0,        0, 32'h80123456, 32'hBFC00000, 4'h8, 32'h0,        32'h00000080, 0, 1, 2};
    vt[3]  = '{1, 2'b01, 0, 32'hBFC00002, 32'h0000ABCD, 0, 32'h0,        32'hBFC00000, 4'hC, 32'hABCD0000, 32'h0,        0, 1, 2};
    vt[4]  = '{0, 2'b10, 0, 32'hBFC00001, 32'h0,        0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 1};
    vt[5]  = '{1, 2'b00, 0, 32'h10000001, 32'h123456A5, 1, 32'h0,        32'h10000000, 4'h2, 32'h0000A500, 32'h0,        0, 2, 3};
    vt[6]  = '{0, 2'b01, 1, 32'h20000000, 32'h0,        0, 32'h1234F00D, 32'h20000000, 4'h3, 32'h0,        32'hFFFFF00D, 0, 1, 2};
    vt[7]  = '{0, 2'b01, 0, 32'h20000002, 32'h0,        0, 32'h80017FFF, 32'h20000000, 4'hC, 32'h0,        32'h00008001, 0, 1, 2};
    vt[8]  = '{0, 2'b01, 1, 32'h20000002, 32'h0,        0, 32'h80017FFF, 32'h20000000, 4'hC, 32'h0,        32'hFFFF8001, 0, 1, 2};
    vt[9]  = '{0, 2'b11, 0, 32'h00000000, 32'h0,        0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 1};
    vt[10] = '{1, 2'b01, 0, 32'h00000003, 32'h0000FFFF, 0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 1};
    vt[11] = '{1, 2'b10, 0, 32'h00000008, 32'hCAFEF00D, 0, 32'h0,        32'h00000008, 4'hF, 32'hCAFEF00D, 32'h0,        0, 1, 2};
    vt[12] = '{0, 2'b00, 1, 32'h00000001, 32'h0,        0, 32'h00007F00, 32'h00000000, 4'h2, 32'h0,        32'h0000007F, 0, 1, 2};
    vt[13] = '{0, 2'b10, 1, 32'h00000010, 32'h0,        1, 32'h80000000, 32'h00000010, 4'hF, 32'h0,        32'h80000000, 0, 2, 3};
    vt[14] = '{1, 2'b00, 0, 32'h0000000B, 32'h000000EE, 0, 32'h0,        32'h00000008, 4'h8, 32'hEE000000, 32'h0,        0, 1, 2};
    vt[15] = '{0, 2'b00, 0, 32'h00000006, 32'h0,        0, 32'h00C30000, 32'h00000004, 4'h4, 32'h0,        32'h000000C3, 0, 1, 2};
    vto    = '{0, 2'b10, 0, 32'h00000020, 32'h0,     1000, 32'h0,        32'h00000020, 4'hF, 32'h0,        32'h0,        1, 4, 5};

    // Reset state, with a request pending on the inputs
    req_valid = 1'b1;
    req_size  = 2'b10;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rdwr", {30'h0, read, write}, 32'h0);
    chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    chk("rst_address", address, 32'h0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_be", {28'h0, byteenable}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    req_valid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vt[i], $sformatf("v%0d", i), 1'b0);

    // req_valid held during the transfer must not start a second one
    run_vec(vt[5], "noise", 1'b1);
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (read || write || resp_valid) quiet = 0;
    end
    chk("noise_not_queued", {31'h0, quiet}, 32'h1);

    // Reset in the middle of a stalled read
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_addr = 32'hBFC00004; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    waitrequest = 1'b1;
    @(negedge clk);
    chk("abort_read_before", {31'h0, read}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("abort_read_dropped", {31'h0, read}, 32'h0);
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || read || write) quiet = 0;
    end
    waitrequest = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    if (resp_valid || read || write) quiet = 0;
    chk("abort_no_resp", {31'h0, quiet}, 32'h1);
    run_vec(vt[0], "after_abort", 1'b0);

`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
    run_vec(vto, "timeout", 1'b0);
`else
    // Without the timeout the master waits on a stuck slave indefinitely
    @(negedge clk);
    req_write = vto.wr; req_size = vto.sz; req_addr = vto.addr; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    waitrequest = 1'b1;
    busy_cnt = 0;
    quiet = 1;
    for (int i = 0; i < 20; i++) begin
      if (read) busy_cnt++;
      if (resp_valid) quiet = 0;
      @(negedge clk);
    end
    chk("stuck_read_held", busy_cnt, 20);
    chk("stuck_no_resp", {31'h0, quiet}, 32'h1);
    #2 rst = 1'b0;
    @(negedge clk);
    waitrequest = 1'b0;
    rst = 1'b1;
    run_vec(vt[11], "after_stuck", 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
